flq_mem_port: RTL and testbench

Memory-side port for the fill queue. It collects the per-entry memory requests of all NUM_FLQ fill-queue entries and grants one per cycle using a round-robin arbiter. Each granted request is held in an in-order outstanding queue for a fixed LATENCY. It then returns a single-cycle t_mem_rsp_pkt, broadcast to every fill-queue entry, with line data read from the backing store. It sits directly downstream of the fill-queue entries' memory handshake and upstream of their response match.

---
 rtl/flq_mem_port_pkg.sv | 40 ++++
 rtl/flq_mem_port_if.sv | 27 ++
 rtl/flq_mem_port_rr_arb.sv | 46 ++++
 rtl/flq_mem_port.sv | 112 +++++++++++
 tb/tb_flq_mem_port.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/flq_mem_port_pkg.sv
// Shared types for the fill-queue memory port: request/response packets, address/data and outstanding slot.
// All widths derive from the localparams below.
package flq_mem_port_pkg;

  localparam int FLQ_NUM     = 8;
  localparam int FLQ_ID_W    = $clog2(FLQ_NUM);
  localparam int PADDR_W     = 32;
  localparam int CL_DATA_W   = 64;
  localparam int CL_OFS_W    = $clog2(CL_DATA_W / 8);
  localparam int MEM_LATENCY = 16;
  localparam int MPS_CNT_W   = 8;

  typedef logic [FLQ_ID_W-1:0]  t_flq_id;
  typedef logic [PADDR_W-1:0]   t_paddr;
  typedef logic [CL_DATA_W-1:0] t_cl_data;

  typedef struct packed {
    logic    valid;
    t_paddr  addr;
    t_flq_id id;
  } t_mem_req_pkt;

  typedef struct packed {
    logic     valid;
    t_flq_id  id;
    t_cl_data data;
  } t_mem_rsp_pkt;

  typedef struct packed {
    logic                 valid;
    t_flq_id              id;
    t_paddr               addr;
    logic [MPS_CNT_W-1:0] cnt;
  } t_mps_slot;

  function automatic t_paddr line_align(input t_paddr a);
    return {a[PADDR_W-1:CL_OFS_W], {CL_OFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/flq_mem_port_if.sv
// Fill-queue <-> memory port bundle: per-entry requests and grants, broadcast response, backing-store read.
// master = fill-queue/backing-store side, slave = the memory port.
interface flq_mem_port_if
  import flq_mem_port_pkg::*;
#(
  parameter int NUM_FLQ = FLQ_NUM,
  parameter int DEPTH   = 4
) ();

  t_mem_req_pkt [NUM_FLQ-1:0] req_pkt;
  logic [NUM_FLQ-1:0]         req_gnt;
  t_mem_rsp_pkt               rsp_pkt;
  t_paddr                     mem_rd_addr;
  t_cl_data                   mem_rd_data;
  logic [$clog2(DEPTH):0]     outstanding_cnt;

  modport master (
    output req_pkt, mem_rd_data,
    input  req_gnt, rsp_pkt, mem_rd_addr, outstanding_cnt
  );

  modport slave (
    input  req_pkt, mem_rd_data,
    output req_gnt, rsp_pkt, mem_rd_addr, outstanding_cnt
  );

endinterface

// File: rtl/flq_mem_port_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant to the first request at/after the pointer.
// Pointer moves to one past the winner on a grant and holds otherwise; callers mask requests to stall.
module rr_arb #(
  parameter int NUM_REQ = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_req,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
  output logic                       o_gnt_vld
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_k;
  int unsigned      w_sum;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_sum     = 0;
    w_k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_k = PTR_W'(w_sum);
      if (!o_gnt_vld && i_req[w_k]) begin
        o_gnt[w_k] = 1'b1;
        o_gnt_idx  = w_k;
        o_gnt_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/flq_mem_port.sv
// Memory port: round-robin grants one fill-queue request per cycle into an in-order queue; each responds LATENCY cycles after grant.
// Backpressure: no grants while the registered occupancy equals DEPTH (no same-cycle bypass on retire).
module flq_mem_port
  import flq_mem_port_pkg::*;
#(
  parameter int NUM_FLQ = FLQ_NUM,
  parameter int LATENCY = MEM_LATENCY,
  parameter int DEPTH   = 4
) (
  input logic            clk,
  input logic            reset,
  flq_mem_port_if.slave  io_mem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  t_mps_slot        r_slot [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [NUM_FLQ-1:0]         w_req;
  logic [NUM_FLQ-1:0]         w_gnt;
  logic [$clog2(NUM_FLQ)-1:0] w_gnt_idx;
  logic                       w_gnt_vld;
  logic                       w_full;
  logic                       w_enq;
  logic                       w_deq;
  logic                       w_dup;
  t_mps_slot                  w_head;
  t_mem_rsp_pkt               w_rsp;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_head = r_slot[r_head];
  // Reset masks both sides so a flushed queue never leaks a grant or a response.
  assign w_deq  = w_head.valid && (w_head.cnt == '0) && !reset;
  assign w_enq  = w_gnt_vld;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_FLQ; i++) begin
      w_req[i] = io_mem.req_pkt[i].valid && !w_full && !reset;
    end
  end

  rr_arb #(.NUM_REQ(NUM_FLQ)) u_arb (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_req     (w_req),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_slot[i].valid && r_slot[i].cnt != '0) r_slot[i].cnt <= r_slot[i].cnt - 1'b1;
      end
      if (w_deq) begin
        r_slot[r_head].valid <= 1'b0;
        r_head               <= r_head + 1'b1;
      end
      // Tail never aliases a retiring head: that needs an empty or a full queue.
      if (w_enq) begin
        r_slot[r_tail] <= '{valid: 1'b1,
                           id:    t_flq_id'(w_gnt_idx),
                           addr:  io_mem.req_pkt[w_gnt_idx].addr,
                           cnt:   MPS_CNT_W'(LATENCY - 1)};
        r_tail         <= r_tail + 1'b1;
      end
      if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
    end
  end

  always_comb begin
    w_rsp = '0;
    if (w_deq) begin
      w_rsp.valid = 1'b1;
      w_rsp.id    = w_head.id;
      w_rsp.data  = io_mem.mem_rd_data;
    end
  end

  assign io_mem.req_gnt         = w_gnt;
  assign io_mem.rsp_pkt         = w_rsp;
  assign io_mem.mem_rd_addr     = w_head.valid ? line_align(w_head.addr) : '0;
  assign io_mem.outstanding_cnt = r_count;

  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_FLQ; i++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (io_mem.req_pkt[i].valid && r_slot[s].valid && r_slot[s].id == io_mem.req_pkt[i].id) w_dup = 1'b1;
      end
    end
  end

  a_no_dup_req:   assert property (@(posedge clk) disable iff (reset) !w_dup);
  a_gnt_onehot0:  assert property (@(posedge clk) disable iff (reset) $onehot0(w_gnt));
  a_no_gnt_full:  assert property (@(posedge clk) disable iff (reset) !(w_full && (|w_gnt)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(w_deq && r_count == '0));
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(w_enq && !w_deq && w_full));

endmodule

// File: tb/tb_flq_mem_port.sv
// Directed bench for flq_mem_port: cycle-table scenarios plus hand-written single-request and mid-flight reset sequences.
module tb_flq_mem_port;
  import flq_mem_port_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  flq_mem_port_if #(.NUM_FLQ(8), .DEPTH(4)) mif ();

  flq_mem_port #(.NUM_FLQ(8), .LATENCY(16), .DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_mem (mif)
  );

  function automatic t_cl_data mem_fn(input t_paddr a);
    return {a, ~a};
  endfunction

  assign mif.mem_rd_data = mem_fn(mif.mem_rd_addr);

  t_paddr addr_map [8];

  typedef struct {
    bit         rst;
    int         n;
    logic [7:0] req;
    logic [7:0] gnt;
    bit         rv;
    int         rid;
    int         cnt;
  } row_t;

  localparam int NROWS = 39;
  row_t tbl [NROWS];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input logic [7:0] m);
    logic [2:0] j;
    reset = rst;
    for (int i = 0; i < 8; i++) begin
      j = 3'(i);
      mif.req_pkt[j].valid = m[j];
      mif.req_pkt[j].addr  = addr_map[j];
      mif.req_pkt[j].id    = j;
    end
  endtask

  task automatic chk(input string nm, input int row, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int row, input logic [7:0] egnt,
                             input bit erv, input int erid, input int ecnt);
    logic [2:0] eid;
    t_cl_data   edat;
    eid  = erv ? erid[2:0] : 3'd0;
    edat = erv ? mem_fn(addr_map[eid]) : '0;
    chk({tag, ".gnt"},      row, 64'(mif.req_gnt),         64'(egnt));
    chk({tag, ".rsp_vld"},  row, 64'(mif.rsp_pkt.valid),   64'(erv));
    chk({tag, ".rsp_id"},   row, 64'(mif.rsp_pkt.id),      64'(eid));
    chk({tag, ".rsp_data"}, row, 64'(mif.rsp_pkt.data),    64'(edat));
    if (ecnt >= 0) chk({tag, ".cnt"}, row, 64'(mif.outstanding_cnt), 64'(ecnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    addr_map = '{32'h2000, 32'h2040, 32'h2080, 32'h1000, 32'h2100, 32'h2140, 32'h2180, 32'h21C0};

    // rst, n, req, gnt, rsp_vld, rsp_id, cnt (-1 = not checked)
    tbl = '{
      // round robin 0,2,5; enq+deq at count 2; 0 loses to 6
      '{1'b1,  2, 8'h00, 8'h00, 1'b0, 0, -1},
      '{1'b0,  1, 8'h25, 8'h01, 1'b0, 0,  0},
      '{1'b0,  1, 8'h24, 8'h04, 1'b0, 0,  1},
      '{1'b0,  1, 8'h20, 8'h20, 1'b0, 0,  2},
      '{1'b0, 13, 8'h00, 8'h00, 1'b0, 0,  3},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 0,  3},
      '{1'b0,  1, 8'h41, 8'h40, 1'b1, 2,  2},
      '{1'b0,  1, 8'h01, 8'h01, 1'b1, 5,  2},
      '{1'b0, 14, 8'h00, 8'h00, 1'b0, 0,  2},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 6,  2},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 0,  1},
      '{1'b0,  1, 8'h00, 8'h00, 1'b0, 0,  0},
      // full backpressure: 5 requesters, DEPTH 4
      '{1'b1,  2, 8'h00, 8'h00, 1'b0, 0, -1},
      '{1'b0,  1, 8'h1F, 8'h01, 1'b0, 0,  0},
      '{1'b0,  1, 8'h1E, 8'h02, 1'b0, 0,  1},
      '{1'b0,  1, 8'h1C, 8'h04, 1'b0, 0,  2},
      '{1'b0,  1, 8'h18, 8'h08, 1'b0, 0,  3},
      '{1'b0, 12, 8'h10, 8'h00, 1'b0, 0,  4},
      '{1'b0,  1, 8'h10, 8'h00, 1'b1, 0,  4},
      '{1'b0,  1, 8'h10, 8'h10, 1'b1, 1,  3},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 2,  3},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 3,  2},
      '{1'b0, 13, 8'h00, 8'h00, 1'b0, 0,  1},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 4,  1},
      '{1'b0,  1, 8'h00, 8'h00, 1'b0, 0,  0},
      // pointer wrap 7 -> 1 -> ptr 2, tail wrap over 6 requests
      '{1'b1,  2, 8'h00, 8'h00, 1'b0, 0, -1},
      '{1'b0,  1, 8'h40, 8'h40, 1'b0, 0,  0},
      '{1'b0,  1, 8'h82, 8'h80, 1'b0, 0,  1},
      '{1'b0,  1, 8'h02, 8'h02, 1'b0, 0,  2},
      '{1'b0,  1, 8'h09, 8'h08, 1'b0, 0,  3},
      '{1'b0, 12, 8'h01, 8'h00, 1'b0, 0,  4},
      '{1'b0,  1, 8'h01, 8'h00, 1'b1, 6,  4},
      '{1'b0,  1, 8'h21, 8'h20, 1'b1, 7,  3},
      '{1'b0,  1, 8'h01, 8'h01, 1'b1, 1,  3},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 3,  3},
      '{1'b0, 13, 8'h00, 8'h00, 1'b0, 0,  2},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 5,  2},
      '{1'b0,  1, 8'h00, 8'h00, 1'b1, 0,  1},
      '{1'b0,  1, 8'h00, 8'h00, 1'b0, 0,  0}
    };

    drive(1'b1, 8'h00);
    next_cycle();
    next_cycle();

    // Single request from entry 3 at cycle 5; response exactly at cycle 21.
    for (int t = 0; t <= 30; t++) begin
      drive(1'b0, (t == 5) ? 8'h08 : 8'h00);
      #2;
      check_cycle("single", t, (t == 5) ? 8'h08 : 8'h00, (t == 21), 3,
                  (t >= 6 && t <= 21) ? 1 : 0);
      chk("single.rd_addr", t, 64'(mif.mem_rd_addr),
          (t >= 6 && t <= 21) ? 64'h1000 : 64'h0);
      next_cycle();
    end

    for (int r = 0; r < NROWS; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        drive(tbl[r].rst, tbl[r].req);
        #2;
        check_cycle("tbl", r, tbl[r].gnt, tbl[r].rv, tbl[r].rid, tbl[r].cnt);
        next_cycle();
      end
    end

    // Mid-flight reset: three outstanding requests are dropped; a later request keeps exact latency.
    drive(1'b1, 8'h00);
    next_cycle();
    next_cycle();
    for (int c = 0; c <= 35; c++) begin
      logic [7:0] m;
      int         ec;
      m  = (c == 0)  ? 8'h16 :
           (c == 1)  ? 8'h14 :
           (c == 2)  ? 8'h10 :
           (c == 10) ? 8'h02 : 8'h00;
      ec = (c <= 2)  ? c :
           (c <= 5)  ? 3 :
           (c <= 10) ? 0 :
           (c <= 26) ? 1 : 0;
      drive(c == 5, m);
      #2;
      if (c != 5) check_cycle("midrst", c, m & ~(8'h04 & {8{c == 0}}) & ~(8'h10 & {8{c <= 1}}),
                              (c == 26), 1, ec);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
